// File: rtl/mul_slice_iter.sv
// Iterative RV M-extension multiplier: consumes SLICE_W bits of |rs2| per cycle,
// accumulating |rs1| * slice into a 2*XLEN accumulator, then applies the sign.
module mul_slice_iter #(
    parameter int XLEN    = 32,
    parameter int SLICE_W = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] result
);

    localparam int NSLICE = (XLEN + SLICE_W - 1) / SLICE_W;
    localparam int BW     = NSLICE * SLICE_W;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int SHW    = $clog2(BW + 1);
    localparam int PW     = XLEN + SLICE_W;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN,
        DONE
    } state_t;

    state_t state, next_state;

    logic [XLEN-1:0]   a_abs;
    logic [BW-1:0]     b_abs;
    logic [1:0]        op_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;

    logic              sign1, sign2;
    logic [XLEN-1:0]   abs1, abs2;
    logic              accept;
    logic              last_slice;
    logic [SHW-1:0]    shamt;
    logic [SLICE_W-1:0] slice;
    logic [PW-1:0]     partial;
    logic [2*XLEN-1:0] acc_add;
    logic [2*XLEN-1:0] prod;

    assign req_ready  = (state == IDLE) && !rst && !flush;
    assign accept     = req_valid && req_ready;
    assign last_slice = (cnt == CW'(NSLICE - 1));

    // Magnitudes are taken up front so the slice loop is purely unsigned;
    // the most-negative value maps to 2^(XLEN-1), which still fits.
    always_comb begin
        sign1 = ((op == OP_MULH) || (op == OP_MULHSU)) && rs1[XLEN-1];
        sign2 = (op == OP_MULH) && rs2[XLEN-1];
        abs1  = sign1 ? (~rs1 + XLEN'(1)) : rs1;
        abs2  = sign2 ? (~rs2 + XLEN'(1)) : rs2;
    end

    always_comb begin
        shamt   = SHW'(cnt) * SHW'(SLICE_W);
        slice   = SLICE_W'(b_abs >> shamt);
        partial = PW'(a_abs) * PW'(slice);
        acc_add = (2*XLEN)'(partial) << shamt;
        prod    = neg_q ? (~acc + (2*XLEN)'(1)) : acc;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept)     next_state = CALC;
            CALC: if (last_slice) next_state = FIN;
            FIN:                  next_state = DONE;
            DONE: if (rsp_ready)  next_state = IDLE;
            default:              next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Flush only has to kill the response; operand and accumulator state is
    // reloaded on the next accept, and result deliberately keeps its old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_abs     <= '0;
            b_abs     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            result    <= '0;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_abs <= abs1;
                        b_abs <= BW'(abs2);
                        op_q  <= op;
                        neg_q <= sign1 ^ sign2;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc <= acc + acc_add;
                    cnt <= cnt + CW'(1);
                end
                FIN: begin
                    result    <= (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    rsp_valid <= 1'b1;
                end
                DONE: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: rsp_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_slice_iter.sv
// Directed self-checking bench for mul_slice_iter (XLEN=32, SLICE_W=11).
module tb_mul_slice_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    localparam int LAT = 4;

    mul_slice_iter #(.XLEN(32), .SLICE_W(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Caller is #1 after a rising edge; returns #1 after the response handshake edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        int n;
        op = o; rs1 = a; rs2 = b; rsp_ready = 1'b1; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        res = result;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
        op = 2'b00; rs1 = 32'd3; rs2 = 32'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready_in_rst: got %b expected 0", req_ready); end
        rst = 1'b0; req_valid = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready_after: got %b expected 1", req_ready); end
    endtask

    task automatic test_basic_mul();
        logic [31:0] res;
        int lat;
        @(posedge clk); #1;
        run_op(2'b00, 32'd7, 32'd6, res, lat);
        checks++; if (res !== 32'h0000002A) begin errors++; $display("[TB] FAIL mul_7x6: got %h expected 0000002a", res); end
        checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL mul_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL req_ready_after_rsp: got %b expected 1", req_ready); end
    endtask

    task automatic test_sign_corners();
        logic [1:0]  t_op [5] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00};
        logic [31:0] t_a  [5] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] t_b  [5] = '{32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] t_e  [5] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], res, lat);
            checks++; if (res !== t_e[i]) begin errors++; $display("[TB] FAIL sign_corner_%0d: got %h expected %h", i, res, t_e[i]); end
            checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL sign_corner_lat_%0d: got %0d expected %0d", i, lat, LAT); end
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        rsp_ready = 1'b0; req_valid = 1'b1; op = 2'b00; rs1 = 32'd3; rs2 = 32'd5;
        @(posedge clk); #1;
        rs1 = 32'd2; rs2 = 32'd2;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected %0d", lat, LAT); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid_%0d: got %b expected 1", i, rsp_valid); end
            checks++; if (result !== 32'd15) begin errors++; $display("[TB] FAIL bp_hold_result_%0d: got %h expected 0000000f", i, result); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_ready_%0d: got %b expected 0", i, req_ready); end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_drop: got %b expected 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_req_ready_back: got %b expected 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++; if (result !== 32'd4) begin errors++; $display("[TB] FAIL bp_second_result: got %h expected 00000004", result); end
        checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL bp_second_latency: got %0d expected %0d", lat, LAT); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat;
        int seen;
        rsp_ready = 1'b1; req_valid = 1'b1; op = 2'b01; rs1 = 32'h12345678; rs2 = 32'h9ABCDEF0;
        flush = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_req_ready: got %b expected 0", req_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_idle_not_taken: got %b expected 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_calc_req_ready: got %b expected 0", req_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_to_idle: got %b expected 1", req_ready); end
        checks++; if (result !== 32'd4) begin errors++; $display("[TB] FAIL flush_result_kept: got %h expected 00000004", result); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL flush_no_response: got %0d valid cycles expected 0", seen); end
        run_op(2'b11, 32'h00010000, 32'h00010000, res, lat);
        checks++; if (res !== 32'h00000001) begin errors++; $display("[TB] FAIL flush_followup_mulhu: got %h expected 00000001", res); end
        checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL flush_followup_latency: got %0d expected %0d", lat, LAT); end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        rsp_ready = 1'b1; req_valid = 1'b1; op = 2'b00; rs1 = 32'h1234; rs2 = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; req_valid = 1'b1; rs1 = 32'd5; rs2 = 32'd5;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_fin_valid: got %b expected 0", rsp_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL rst_fin_result: got %h expected 00000000", result); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_ready: got %b expected 0", req_ready); end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_req_ignored: got %b expected 1", req_ready); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL rst_no_response: got %0d valid cycles expected 0", seen); end
    endtask

    task automatic test_random_ops();
        logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] a, b, res, exp_v;
        logic [1:0]  o;
        int lat;
        for (int i = 0; i < 200; i++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            exp_v = ref_mul(o, a, b);
            run_op(o, a, b, res, lat);
            checks++; if (res !== exp_v) begin errors++; $display("[TB] FAIL rand_%0d op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, res, exp_v); end
            checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL rand_lat_%0d: got %0d expected %0d", i, lat, LAT); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_mul();
        test_sign_corners();
        test_back_pressure();
        test_flush();
        test_reset_mid_op();
        test_random_ops();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
